// File: rtl/vector_chunk_alu.sv
// vector_chunk_alu: latches two signed vectors and processes LANES elements per clock into S, with a running reduction sum.
// Optional macro VECTOR_ALU_SAT_EN: ADD/SUB/MUL saturate to BITS instead of wrapping.
module vector_chunk_alu #(
   parameter int BITS       = 8,
   parameter int N          = 16,
   parameter int LANES      = 4,
   parameter int MULT_SHIFT = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N*BITS-1:0]         A,
   input  logic [7:0]                A_len,
   input  logic [N*BITS-1:0]         B,
   input  logic [7:0]                B_len,
   input  logic [BITS-1:0]           scalar,
   input  logic [2:0]                op_sel,
   input  logic                      scalar_sel,
   input  logic                      start,
   input  logic                      en,
   output logic                      busy,
   output logic                      done,
   output logic [N*BITS-1:0]         S,
   output logic [7:0]                S_len,
   output logic [BITS+$clog2(N)-1:0] red_sum
);
   localparam int RW = BITS + $clog2(N);
   localparam int WW = 2*BITS + 1;
   localparam logic [7:0] N_LEN = 8'(N);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
`ifdef VECTOR_ALU_SAT_EN
   localparam logic signed [WW-1:0] SAT_MAX = WW'((2**(BITS-1)) - 1);
   localparam logic signed [WW-1:0] SAT_MIN = WW'(-(2**(BITS-1)));
`endif

   function automatic logic signed [BITS-1:0] narrow(input logic signed [WW-1:0] v);
`ifdef VECTOR_ALU_SAT_EN
      if (v > SAT_MAX)      return SAT_MAX[BITS-1:0];
      else if (v < SAT_MIN) return SAT_MIN[BITS-1:0];
      else                  return BITS'(v);
`else
      return BITS'(v);
`endif
   endfunction

   function automatic logic signed [BITS-1:0] alu(input logic [2:0] op,
                                                  input logic signed [BITS-1:0] a,
                                                  input logic signed [BITS-1:0] b);
      logic signed [WW-1:0]     aw, bw, pw;
      logic        [2*BITS-1:0] ax, bx;
      logic signed [2*BITS-1:0] prod;
      aw   = $signed({{(BITS+1){a[BITS-1]}}, a});
      bw   = $signed({{(BITS+1){b[BITS-1]}}, b});
      // low 2*BITS bits of the sign-extended product equal the signed product
      ax   = {{BITS{a[BITS-1]}}, a};
      bx   = {{BITS{b[BITS-1]}}, b};
      prod = $signed(ax * bx);
      pw   = $signed({prod[2*BITS-1], prod}) >>> MULT_SHIFT;
      case (op)
         3'd0:    alu = narrow(aw + bw);
         3'd1:    alu = narrow(aw - bw);
         3'd2:    alu = narrow(pw);
         3'd3:    alu = a & b;
         3'd4:    alu = a | b;
         3'd5:    alu = a ^ b;
         3'd6:    alu = (a > b) ? a : b;
         default: alu = (a < b) ? a : b;
      endcase
   endfunction

   logic [1:0]             state_q, state_d;
   logic [N*BITS-1:0]      a_q, a_d, b_q, b_d, s_q, s_d;
   logic [2:0]             op_q, op_d;
   logic [7:0]             len_q, len_d, k_q, k_d;
   logic signed [RW-1:0]   sum_q, sum_d;
   logic [7:0]             len_req;
   logic signed [BITS-1:0] lane_a [LANES];
   logic signed [BITS-1:0] lane_b [LANES];
   logic signed [BITS-1:0] lane_r [LANES];
   logic signed [RW-1:0]   chunk_sum, lane_ext;

   always_comb begin
      for (int j = 0; j < LANES; j++) begin
         lane_a[j] = '0;
         lane_b[j] = '0;
      end
      for (int i = 0; i < N; i++) begin
         if (i / LANES == int'(k_q)) begin
            lane_a[i % LANES] = a_q[i*BITS +: BITS];
            lane_b[i % LANES] = b_q[i*BITS +: BITS];
         end
      end
      chunk_sum = '0;
      lane_ext  = '0;
      for (int j = 0; j < LANES; j++) begin
         if (int'(k_q) * LANES + j < int'(len_q)) lane_r[j] = alu(op_q, lane_a[j], lane_b[j]);
         else                                      lane_r[j] = '0;
         lane_ext  = $signed({{(RW-BITS){lane_r[j][BITS-1]}}, lane_r[j]});
         chunk_sum = chunk_sum + lane_ext;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      op_d    = op_q;
      len_d   = len_q;
      k_d     = k_q;
      sum_d   = sum_q;
      len_req = scalar_sel ? A_len : ((A_len < B_len) ? A_len : B_len);
      if (en) begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  a_d     = A;
                  b_d     = scalar_sel ? {N{scalar}} : B;
                  op_d    = op_sel;
                  len_d   = (len_req > N_LEN) ? N_LEN : len_req;
                  s_d     = '0;
                  sum_d   = '0;
                  k_d     = '0;
                  state_d = (len_d == 8'd0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               for (int i = 0; i < N; i++) begin
                  if (i / LANES == int'(k_q)) s_d[i*BITS +: BITS] = lane_r[i % LANES];
               end
               sum_d = sum_q + chunk_sum;
               k_d   = k_q + 8'd1;
               if ((int'(k_q) + 1) * LANES >= int'(len_q)) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         op_q    <= '0;
         len_q   <= '0;
         k_q     <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         op_q    <= op_d;
         len_q   <= len_d;
         k_q     <= k_d;
         sum_q   <= sum_d;
      end
   end

   assign busy    = (state_q != ST_IDLE);
   assign done    = (state_q == ST_DONE);
   assign S       = s_q;
   assign S_len   = len_q;
   assign red_sum = sum_q;
endmodule

// File: tb/tb_vector_chunk_alu.sv
// Scoreboard bench for vector_chunk_alu: directed operations push expected results, a monitor checks each done pulse.
`timescale 1ns/1ps
module tb_vector_chunk_alu;
   localparam int BITS  = 8;
   localparam int N     = 16;
   localparam int LANES = 4;
   localparam int RW    = BITS + $clog2(N);
`ifdef VECTOR_ALU_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [N*BITS-1:0]   A = '0, B = '0;
   logic [7:0]          A_len = '0, B_len = '0;
   logic [BITS-1:0]     scalar = '0;
   logic [2:0]          op_sel = '0;
   logic                scalar_sel = 1'b0, start = 1'b0, en = 1'b1;
   logic                busy, done;
   logic [N*BITS-1:0]   S;
   logic [7:0]          S_len;
   logic [RW-1:0]       red_sum;

   vector_chunk_alu #(.BITS(BITS), .N(N), .LANES(LANES), .MULT_SHIFT(0)) dut (
      .clk(clk), .rst_n(rst_n), .A(A), .A_len(A_len), .B(B), .B_len(B_len),
      .scalar(scalar), .op_sel(op_sel), .scalar_sel(scalar_sel), .start(start), .en(en),
      .busy(busy), .done(done), .S(S), .S_len(S_len), .red_sum(red_sum));

   always #5 clk = ~clk;

   typedef struct {
      logic [N*BITS-1:0] s;
      int                slen;
      int                red;
      int                cyc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   av[N], bv[N], ev[N];
   logic last_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endfunction

   function automatic logic [N*BITS-1:0] pack(input int v[N]);
      logic [N*BITS-1:0] p;
      for (int i = 0; i < N; i++) p[i*BITS +: BITS] = v[i][BITS-1:0];
      return p;
   endfunction

   task automatic clr();
      for (int i = 0; i < N; i++) begin
         av[i] = 0;
         bv[i] = 0;
         ev[i] = 0;
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         check("done_width", int'(last_done), 0);
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: actual=done at cycle %0d required=no done", cyc);
         end else begin
            mon_e = q.pop_front();
            check("done_cycle", cyc, mon_e.cyc);
            check("S_len", int'(S_len), mon_e.slen);
            check("red_sum", int'($signed(red_sum)), mon_e.red);
            checks++;
            if (S !== mon_e.s) begin
               errors++;
               $display("FAIL S: actual=%h required=%h", S, mon_e.s);
            end
         end
      end
      last_done = done;
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", q.size(), 0);
      q.delete();
      @(negedge clk);
   endtask

   task automatic run_op(input logic [2:0] op, input logic ssel, input int sc,
                         input int alen, input int blen, input int eslen,
                         input int ered, input int c, input int stall);
      exp_t e;
      @(negedge clk);
      A          = pack(av);
      B          = pack(bv);
      A_len      = alen[7:0];
      B_len      = blen[7:0];
      scalar     = sc[BITS-1:0];
      op_sel     = op;
      scalar_sel = ssel;
      start      = 1'b1;
      @(posedge clk);
      #1;
      e.s    = pack(ev);
      e.slen = eslen;
      e.red  = ered;
      e.cyc  = cyc + c + stall;
      q.push_back(e);
      start  = 1'b0;
      A      = '1;
      B      = '1;
      scalar = '1;
      A_len  = 8'd0;
      B_len  = 8'd0;
      if (stall > 0) begin
         @(negedge clk);
         op_sel = 3'd0;
         A_len  = 8'd3;
         start  = 1'b1;
         @(negedge clk);
         start = 1'b0;
         en    = 1'b0;
         repeat (stall) @(negedge clk);
         en = 1'b1;
      end
      wait_idle();
   endtask

   initial begin
      #12;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_S_len", int'(S_len), 0);
      check("rst_red_sum", int'(red_sum), 0);
      check("rst_S_zero", int'(S == '0), 1);
      @(negedge clk);
      rst_n = 1'b1;

      // ADD with broadcast -1
      clr();
      av[0] = 0; av[1] = 5; av[2] = 10; av[3] = 20;
      ev[0] = -1; ev[1] = 4; ev[2] = 9; ev[3] = 19;
      run_op(3'd0, 1'b1, -1, 4, 0, 4, 31, 1, 0);

      // SUB vector-vector, length limited by B_len
      clr();
      for (int i = 0; i < N; i++) begin
         av[i] = i + 10;
         bv[i] = i;
      end
      for (int i = 0; i < 7; i++) ev[i] = 10;
      run_op(3'd1, 1'b0, 0, 10, 7, 7, 70, 2, 0);

      // MUL 100*2 narrowing
      clr();
      av[0] = 100; bv[0] = 2;
      ev[0] = SAT ? 127 : -56;
      run_op(3'd2, 1'b0, 0, 1, 1, 1, ev[0], 1, 0);

      // ADD 100+100 narrowing
      clr();
      av[0] = 100; bv[0] = 100;
      ev[0] = SAT ? 127 : -56;
      run_op(3'd0, 1'b0, 0, 1, 1, 1, ev[0], 1, 0);

      // zero length: immediate done, S cleared from previous op
      clr();
      av[0] = 7; bv[0] = 7;
      run_op(3'd0, 1'b0, 0, 0, 5, 0, 0, 0, 0);

      // A_len=200 clamps to N; XOR with broadcast 15
      clr();
      for (int i = 0; i < N; i++) begin
         av[i] = i;
         ev[i] = 15 - i;
      end
      run_op(3'd5, 1'b1, 15, 200, 0, 16, 120, 4, 0);

      // OR with broadcast 0x30
      clr();
      for (int i = 0; i < 4; i++) begin
         av[i] = i;
         ev[i] = 48 + i;
      end
      run_op(3'd4, 1'b1, 48, 4, 0, 4, 198, 1, 0);

      // AND vector-vector
      clr();
      av[0] = 127; av[1] = 85; av[2] = -1; av[3] = 15;
      bv[0] = 15;  bv[1] = 15; bv[2] = 51; bv[3] = -16;
      ev[0] = 15;  ev[1] = 5;  ev[2] = 51; ev[3] = 0;
      run_op(3'd3, 1'b0, 0, 4, 4, 4, 71, 1, 0);

      // MAX signed
      clr();
      av[0] = -5; av[1] = 3;  av[2] = -128; av[3] = 127;
      bv[0] = 2;  bv[1] = -7; bv[2] = -127; bv[3] = 0;
      ev[0] = 2;  ev[1] = 3;  ev[2] = -127; ev[3] = 127;
      run_op(3'd6, 1'b0, 0, 4, 4, 4, 5, 1, 0);

      // MIN signed, same operands
      ev[0] = -5; ev[1] = -7; ev[2] = -128; ev[3] = 0;
      run_op(3'd7, 1'b0, 0, 4, 4, 4, -140, 1, 0);

      // SUB overflow in both directions
      clr();
      av[0] = -128; av[1] = 50;
      bv[0] = 1;    bv[1] = -100;
      ev[0] = SAT ? -128 : 127;
      ev[1] = SAT ? 127 : -106;
      run_op(3'd1, 1'b0, 0, 2, 2, 2, SAT ? -1 : 21, 1, 0);

      // MIN against broadcast 0 with a 3-cycle enable stall and an ignored start
      clr();
      for (int i = 0; i < 8; i++) begin
         av[i] = i - 8;
         ev[i] = i - 8;
      end
      run_op(3'd7, 1'b1, 0, 8, 0, 8, -36, 2, 3);

      // asynchronous reset mid-RUN
      clr();
      @(negedge clk);
      for (int i = 0; i < N; i++) av[i] = i;
      A          = pack(av);
      A_len      = 8'd16;
      scalar     = 8'd15;
      op_sel     = 3'd5;
      scalar_sel = 1'b1;
      start      = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_S_len", int'(S_len), 0);
      check("midrst_red_sum", int'(red_sum), 0);
      check("midrst_S_zero", int'(S == '0), 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // normal operation after reset
      clr();
      av[0] = 0; av[1] = 5; av[2] = 10; av[3] = 20;
      ev[0] = -1; ev[1] = 4; ev[2] = 9; ev[3] = 19;
      run_op(3'd0, 1'b1, -1, 4, 0, 4, 31, 1, 0);

      repeat (5) @(negedge clk);
      check("queue_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/vector_chunk_alu.md
# vector_chunk_alu

Multi-cycle, parametrised successor to the single-shot vector element ALU. It latches two signed vectors (or a vector and a broadcast scalar) on a start handshake. It then processes them LANES elements per clock into a registered result vector, and also accumulates a signed reduction sum of the result elements. The block sits between the vector register file and the host-facing command decoder, and reports completion with a one-cycle `done` pulse.

## Interface
- `BITS`, 8: element width; all elements are signed two's complement.
- `N`, 16: vector depth, in elements. Must be a multiple of `LANES`.
- `LANES`, 4: elements processed per clock.
- `MULT_SHIFT`, 0: arithmetic right shift applied to the 2·BITS product before narrowing.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `A`  in  [BITS-1:0] x N  operand vector A.
- `A_len`  in  8  valid length of A.
- `B`  in  [BITS-1:0] x N  operand vector B.
- `B_len`  in  8  valid length of B.
- `scalar`  in  BITS  broadcast operand.
- `op_sel`  in  3  operation code: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR, 6 MAX, 7 MIN.
- `scalar_sel`  in  1  1 = use `scalar` in place of B.
- `start`  in  1  request; accepted only in IDLE.
- `en`  in  1  clock enable; when 0 all state holds, including the FSM, counters, S and done.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle completion pulse.
- `S`  out  [BITS-1:0] x N  result vector.
- `S_len`  out  8  result length.
- `red_sum`  out  BITS+$clog2(N)  signed sum of `S[0..S_len-1]`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with `start`=1 and `en`=1, latch A, B/scalar, `op_sel` and `scalar_sel`.
  - Compute L = min(A_len, B_len), or L = A_len when `scalar_sel`=1. Clamp L to N and register it as `S_len`.
  - Clear S to all zero and clear `red_sum`. Set chunk counter k=0.
  - Next state is RUN if L>0, otherwise DONE.
- RUN:
  - Each enabled edge computes elements k·LANES … k·LANES+LANES-1 and writes them to S.
  - Lanes with index ≥ L write 0.
  - The sum of the chunk's lane results is added to `red_sum`.
  - k increments. After the chunk that contains index L-1, the next state is DONE.
- DONE: `done`=1 for exactly one cycle; the next enabled edge returns to IDLE.
- `start` in RUN or DONE is ignored; it is not queued.
- Arithmetic, computed at full width before narrowing:
  - ADD/SUB: computed at BITS+1 bits.
  - MUL: 2·BITS product, then arithmetic shift right by `MULT_SHIFT`.
  - AND, OR, XOR: bitwise.
  - MAX/MIN: signed compare.
  - Narrowing to BITS follows Configuration.
- `red_sum` is signed and sized so it never overflows for N elements.
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - S = 0, `S_len` = 0, `red_sum` = 0, `busy` = 0, `done` = 0, k = 0.
  - Reset mid-RUN abandons the operation and no `done` is issued.

## Timing
- Let C = ceil(L/LANES).
- The start edge is edge 0. `done` is high in the cycle after edge C; with L=0, it is high after edge 0.
- S and `red_sum` are final and stable while `done`=1, and hold until the next accepted start.
- `S_len` is valid from the cycle after the start edge.
- Operand inputs may change freely after the start edge.
- Each cycle with `en`=0 adds one cycle of latency.
- Back-to-back throughput: one operation per C+2 cycles.

## Configuration
- `VECTOR_ALU_SAT_EN`: applies to ADD, SUB and MUL.
  - Defined: results saturate to [-2^(BITS-1), 2^(BITS-1)-1].
  - Undefined: results wrap by truncation to BITS bits.
- Logical ops and MAX/MIN are unaffected either way.
- `red_sum` always sums the already-narrowed S elements.

## Test plan
All scenarios use BITS=8, N=16, LANES=4, MULT_SHIFT=0.
- ADD, `scalar_sel`=1, `scalar`=-1, A=[0,5,10,20], `A_len`=4 -> S[0..3]=[-1,4,9,19], S[4..15]=0, `S_len`=4, `red_sum`=31, `done` after edge 1.
- SUB vector-vector, `A_len`=10, `B_len`=7, A[i]=i+10, B[i]=i -> `S_len`=7, S[0..6]=10, S[7..15]=0, `red_sum`=70, `done` after edge 2.
- MUL 100×2 and ADD 100+100 -> 127 with `VECTOR_ALU_SAT_EN` defined; -56 without it.
- `A_len`=0 -> `done` after edge 0, S all zero, `red_sum`=0. Separately, `A_len`=200 clamps to `S_len`=16 and finishes after 4 RUN edges.
- `en`=0 held for 3 cycles mid-RUN -> `done` is delayed exactly 3 cycles with an unchanged result. A `start` pulse while `busy` is ignored.
- `rst_n` low mid-RUN -> all outputs read 0 immediately with no `done`. After release, a new start runs normally.
